// File: rtl/mdu.sv
// mdu: multiply/divide unit with HI/LO registers, fixed-latency MULT/DIV and abortable operations.
// Define MDU_DIV_EN to build the divider; without it DIV/DIVU are accepted as no-ops.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MduOp,
  input  logic        Start,
  input  logic        Cancel,
  input  logic        RdSel,
  output logic        Busy,
  output logic [31:0] Rd
);
  localparam logic [2:0] MDU_MULT  = 3'd1;
  localparam logic [2:0] MDU_MULTU = 3'd2;
  localparam logic [2:0] MDU_MTHI  = 3'd5;
  localparam logic [2:0] MDU_MTLO  = 3'd6;
`ifdef MDU_DIV_EN
  localparam logic [2:0] MDU_DIV   = 3'd3;
  localparam logic [2:0] MDU_DIVU  = 3'd4;
`endif
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  typedef enum logic [1:0] {
    IDLE,
    MUL
`ifdef MDU_DIV_EN
    , DIV
`endif
  } state_t;

  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0] hi, hi_n, lo, lo_n, op_a, op_a_n, op_b, op_b_n;
  logic sgn, sgn_n;
  logic [63:0] prod_s, prod_u, res;

  assign prod_s = $signed({{32{op_a[31]}}, op_a}) * $signed({{32{op_b[31]}}, op_b});
  assign prod_u = {32'b0, op_a} * {32'b0, op_b};

`ifdef MDU_DIV_EN
  logic [31:0] da, db, dq, dr, div_hi, div_lo;
  // Signed divide runs on magnitudes; the 0x80000000 / -1 case falls out as q = 0x80000000, r = 0.
  assign da = sgn && op_a[31] ? -op_a : op_a;
  assign db = sgn && op_b[31] ? -op_b : op_b;
  assign dq = db == '0 ? '0 : da / db;
  assign dr = db == '0 ? '0 : da % db;
  assign div_lo = op_b == '0 ? '1 : (sgn && (op_a[31] ^ op_b[31]) ? -dq : dq);
  assign div_hi = op_b == '0 ? op_a : (sgn && op_a[31] ? -dr : dr);
  assign res = state == DIV ? {div_hi, div_lo} : (sgn ? prod_s : prod_u);
`else
  assign res = sgn ? prod_s : prod_u;
`endif

  assign Busy = state != IDLE;
  assign Rd = RdSel ? hi : lo;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      op_a  <= '0;
      op_b  <= '0;
      sgn   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      hi    <= hi_n;
      lo    <= lo_n;
      op_a  <= op_a_n;
      op_b  <= op_b_n;
      sgn   <= sgn_n;
    end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hi_n    = hi;
    lo_n    = lo;
    op_a_n  = op_a;
    op_b_n  = op_b;
    sgn_n   = sgn;
    case (state)
      IDLE:
        if (Start && !Cancel) begin
          if (MduOp == MDU_MULT || MduOp == MDU_MULTU) begin
            state_n = MUL;
            cnt_n   = CW'(MULT_CYCLES - 1);
            op_a_n  = A;
            op_b_n  = B;
            sgn_n   = MduOp == MDU_MULT;
          end
`ifdef MDU_DIV_EN
          else if (MduOp == MDU_DIV || MduOp == MDU_DIVU) begin
            state_n = DIV;
            cnt_n   = CW'(DIV_CYCLES - 1);
            op_a_n  = A;
            op_b_n  = B;
            sgn_n   = MduOp == MDU_DIV;
          end
`endif
          else if (MduOp == MDU_MTHI) hi_n = A;
          else if (MduOp == MDU_MTLO) lo_n = A;
        end
      default:
        if (Cancel) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == '0) begin
          state_n = IDLE;
          {hi_n, lo_n} = res;
        end else cnt_n = cnt - CW'(1);
    endcase
  end
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: randomized and directed checks of mdu against an arithmetic HI/LO reference model.
module tb_mdu;
  localparam logic [2:0] OP_MULT = 3'd1, OP_MULTU = 3'd2, OP_DIV = 3'd3, OP_DIVU = 3'd4,
                         OP_MTHI = 3'd5, OP_MTLO = 3'd6;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [2:0] mdu_op = '0;
  logic start = 1'b0, cancel = 1'b0, rd_sel = 1'b0;
  logic busy;
  logic [31:0] rd;
  logic [31:0] hi_m = '0, lo_m = '0;
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  mdu dut (.clk(clk), .rst_n(rst_n), .A(a), .B(b), .MduOp(mdu_op), .Start(start),
           .Cancel(cancel), .RdSel(rd_sel), .Busy(busy), .Rd(rd));

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    rd_sel = 1'b1;
    #1 h = rd;
    rd_sel = 1'b0;
    #1 l = rd;
  endtask

  // Reference: architectural HI/LO result and expected Busy length of one accepted op.
  task automatic model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y, output int cyc);
    longint p;
    logic [63:0] pu;
    int sx, sy;
    cyc = 0;
    sx = x;
    sy = y;
    case (op)
      OP_MULT: begin
        p = longint'(sx) * longint'(sy);
        {hi_m, lo_m} = p;
        cyc = 5;
      end
      OP_MULTU: begin
        pu = {32'b0, x} * {32'b0, y};
        {hi_m, lo_m} = pu;
        cyc = 5;
      end
`ifdef MDU_DIV_EN
      OP_DIV, OP_DIVU: begin
        cyc = 10;
        if (y == 0) begin
          lo_m = 32'hFFFF_FFFF;
          hi_m = x;
        end else if (op == OP_DIV && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          lo_m = 32'h8000_0000;
          hi_m = 0;
        end else if (op == OP_DIV) begin
          lo_m = sx / sy;
          hi_m = sx % sy;
        end else begin
          lo_m = x / y;
          hi_m = x % y;
        end
      end
`endif
      OP_MTHI: hi_m = x;
      OP_MTLO: lo_m = x;
      default: ;
    endcase
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                       output int n, output logic busy0);
    mdu_op = op;
    a = x;
    b = y;
    start = 1'b1;
    #1 busy0 = busy;
    step();
    start = 1'b0;
    mdu_op = '0;
    a = $urandom;
    b = $urandom;
    n = 0;
    while (busy && n < 100) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    #2;
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    rd_sel = 1'b0;
    #1;
    n_tests++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", rd); end
    rd_sel = 1'b1;
    #1;
    n_tests++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", rd); end
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [2:0] ops[6] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_DIV, OP_DIVU};
    logic [31:0] xs[6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFF0};
    logic [31:0] ys[6] = '{32'd3, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd3};
    int n, cyc;
    logic b0;
    logic [31:0] h, l;
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], xs[i], ys[i], n, b0);
      model(ops[i], xs[i], ys[i], cyc);
      read_hilo(h, l);
      n_tests++;
      if (b0 !== 1'b0) begin n_fail++; $display("FAIL dir%0d_busy_at_start: got %b want 0", i, b0); end
      n_tests++;
      if (n !== cyc) begin n_fail++; $display("FAIL dir%0d_busy_len: got %0d want %0d", i, n, cyc); end
      n_tests++;
      if (h !== hi_m) begin n_fail++; $display("FAIL dir%0d_hi: got %h want %h", i, h, hi_m); end
      n_tests++;
      if (l !== lo_m) begin n_fail++; $display("FAIL dir%0d_lo: got %h want %h", i, l, lo_m); end
    end
  endtask

  task automatic test_random();
    logic [31:0] sp[4] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [2:0] op;
    logic [31:0] x, y, h, l;
    int n, cyc;
    logic b0;
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(1, 6));
      x = $urandom_range(0, 3) == 0 ? sp[$urandom_range(0, 3)] : $urandom;
      y = $urandom_range(0, 3) == 0 ? sp[$urandom_range(0, 3)] : $urandom;
      issue(op, x, y, n, b0);
      model(op, x, y, cyc);
      read_hilo(h, l);
      n_tests++;
      if (n !== cyc) begin n_fail++; $display("FAIL rnd%0d_busy_len op%0d: got %0d want %0d", i, op, n, cyc); end
      n_tests++;
      if (h !== hi_m) begin n_fail++; $display("FAIL rnd%0d_hi op%0d %h %h: got %h want %h", i, op, x, y, h, hi_m); end
      n_tests++;
      if (l !== lo_m) begin n_fail++; $display("FAIL rnd%0d_lo op%0d %h %h: got %h want %h", i, op, x, y, l, lo_m); end
    end
  endtask

  task automatic test_cancel();
    int n, cyc;
    logic b0;
    logic [31:0] h, l;
    issue(OP_MTHI, 32'h1234, 32'h0, n, b0);
    model(OP_MTHI, 32'h1234, 32'h0, cyc);
    for (int k = 3; k <= 5; k += 2) begin
      mdu_op = OP_MULT;
      a = 32'd2 + k;
      b = 32'd3;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c < k; c++) step();
      cancel = 1'b1;
      step();
      cancel = 1'b0;
      n_tests++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL cancel_c%0d_busy: got %b want 0", k, busy); end
      read_hilo(h, l);
      n_tests++;
      if (h !== hi_m) begin n_fail++; $display("FAIL cancel_c%0d_hi: got %h want %h", k, h, hi_m); end
      n_tests++;
      if (l !== lo_m) begin n_fail++; $display("FAIL cancel_c%0d_lo: got %h want %h", k, l, lo_m); end
    end
    mdu_op = OP_MTLO;
    a = ~lo_m;
    start = 1'b1;
    cancel = 1'b1;
    step();
    mdu_op = OP_MULT;
    step();
    start = 1'b0;
    cancel = 1'b0;
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_cancel_busy: got %b want 0", busy); end
    read_hilo(h, l);
    n_tests++;
    if (l !== lo_m) begin n_fail++; $display("FAIL idle_cancel_lo: got %h want %h", l, lo_m); end
  endtask

  task automatic test_no_forward();
    logic [31:0] v;
    v = ~lo_m;
    rd_sel = 1'b0;
    mdu_op = OP_MTLO;
    a = v;
    start = 1'b1;
    #1;
    n_tests++;
    if (rd !== lo_m) begin n_fail++; $display("FAIL no_forward_same_cycle: got %h want %h", rd, lo_m); end
    step();
    start = 1'b0;
    lo_m = v;
    n_tests++;
    if (rd !== v) begin n_fail++; $display("FAIL mtlo_next_cycle: got %h want %h", rd, v); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] op1;
    logic [31:0] x, y, h, l;
    int n, cyc;
`ifdef MDU_DIV_EN
    op1 = OP_DIV;
`else
    op1 = OP_MULT;
`endif
    x = $urandom;
    y = $urandom_range(1, 1000);
    mdu_op = op1;
    a = x;
    b = y;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      start = n == 2;
      mdu_op = OP_MULT;
      a = 32'd3;
      b = 32'd5;
      step();
    end
    start = 1'b0;
    model(op1, x, y, cyc);
    n_tests++;
    if (n !== cyc) begin n_fail++; $display("FAIL b2b_busy_len: got %0d want %0d", n, cyc); end
    step();
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_second_started: got %b want 0", busy); end
    read_hilo(h, l);
    n_tests++;
    if (h !== hi_m) begin n_fail++; $display("FAIL b2b_hi: got %h want %h", h, hi_m); end
    n_tests++;
    if (l !== lo_m) begin n_fail++; $display("FAIL b2b_lo: got %h want %h", l, lo_m); end
  endtask

  task automatic test_async_reset();
    logic [31:0] h, l;
`ifdef MDU_DIV_EN
    mdu_op = OP_DIV;
`else
    mdu_op = OP_MULT;
`endif
    a = $urandom | 32'h100;
    b = 32'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy: got %b want 0", busy); end
    read_hilo(h, l);
    n_tests++;
    if (h !== 32'h0 || l !== 32'h0) begin n_fail++; $display("FAIL async_reset_hilo: got %h_%h want 0_0", h, l); end
    hi_m = '0;
    lo_m = '0;
    step();
    step();
    rst_n = 1'b1;
    mdu_op = OP_MTLO;
    a = 32'd5;
    rd_sel = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    n_tests++;
    if (rd !== 32'd5) begin n_fail++; $display("FAIL first_start_after_reset: got %h want 5", rd); end
    for (int i = 0; i < 15; i++) step();
    read_hilo(h, l);
    n_tests++;
    if (busy !== 1'b0 || h !== 32'h0 || l !== 32'd5) begin
      n_fail++;
      $display("FAIL no_commit_after_reset: got busy %b hi %h lo %h want 0 0 5", busy, h, l);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_cancel();
    test_no_forward();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
